// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and the key-schedule round-constant table.
// Used by both the inverse key schedule and the encryption path.
package aes_pkg;

   localparam int AES_NR     = 10;
   localparam int AES_KEY_W  = 128;
   localparam int AES_BYTE_W = 8;
   localparam int AES_WORD_W = 32;

   typedef enum logic {
      IDLE,
      EMIT
   } ksState_t;

   // Round constant used when stepping the key schedule across round r (r = 1..10).
   function automatic logic [AES_BYTE_W-1:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
// The table is shared with the encryption path; SubWord uses four copies.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [AES_BYTE_W-1:0] i_in,
   output logic [AES_BYTE_W-1:0] o_out
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign o_out = SBOX[i_in];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse-order AES-128 round-key generator for the decryption path.
// Loads the round-10 key and streams round keys 10 down to 0 on a valid/ready
// interface, running the key recurrence backwards so only one key is stored.
// Optional feature macro: AES_INV_KS_ZEROIZE_EN clears the key register once
// the round-0 key has been consumed and masks rk while rk_valid is low.
module aes_inv_key_sched
   import aes_pkg::*;
#(
   parameter int NR    = AES_NR,
   parameter int KEY_W = AES_KEY_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [KEY_W-1:0] i_last_key,
   output logic             o_rk_valid,
   input  logic             i_rk_ready,
   output logic [KEY_W-1:0] o_rk,
   output logic [3:0]       o_rk_round,
   output logic             o_busy,
   output logic             o_done
);

   ksState_t                r_state;
   logic [KEY_W-1:0]        r_key;
   logic [3:0]              r_round;
   logic                    r_valid;
   logic                    r_busy;
   logic                    r_done;

   logic [AES_WORD_W-1:0]   w_w0, w_w1, w_w2, w_w3;
   logic [AES_WORD_W-1:0]   w_p0, w_p1, w_p2, w_p3;
   logic [AES_WORD_W-1:0]   w_rot;
   logic [AES_WORD_W-1:0]   w_sub;
   logic [KEY_W-1:0]        w_prevKey;
   logic                    w_xfer;

   assign w_w0 = r_key[127:96];
   assign w_w1 = r_key[95:64];
   assign w_w2 = r_key[63:32];
   assign w_w3 = r_key[31:0];

   // Undoing the forward recurrence: the three upper words fall out by XOR
   // of neighbours, and the recovered w3 of the previous round feeds SubWord.
   assign w_p3 = w_w3 ^ w_w2;
   assign w_p2 = w_w2 ^ w_w1;
   assign w_p1 = w_w1 ^ w_w0;
   assign w_rot = {w_p3[23:0], w_p3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_subWord
      aes_sbox u_sbox (
         .i_in  (w_rot[g*AES_BYTE_W +: AES_BYTE_W]),
         .o_out (w_sub[g*AES_BYTE_W +: AES_BYTE_W])
      );
   end

   assign w_p0      = w_w0 ^ w_sub ^ {rcon(r_round), 24'h0};
   assign w_prevKey = {w_p0, w_p1, w_p2, w_p3};
   assign w_xfer    = r_valid && i_rk_ready;

   // Two-state sequencer: load on start, then step back one round per accepted key.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_key   <= '0;
         r_round <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_key   <= i_last_key;
                  r_round <= 4'(NR);
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= EMIT;
               end
            end
            EMIT: begin
               if (w_xfer) begin
                  if (r_round != 4'd0) begin
                     r_key   <= w_prevKey;
                     r_round <= r_round - 4'd1;
                  end else begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
`ifdef AES_INV_KS_ZEROIZE_EN
                     r_key   <= '0;
`endif
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef AES_INV_KS_ZEROIZE_EN
   assign o_rk = r_valid ? r_key : '0;
`else
   assign o_rk = r_key;
`endif

   assign o_rk_valid = r_valid;
   assign o_rk_round = r_round;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched.
// Expected keys come from a forward FIPS-197 key expansion kept here, using an
// S-box computed from GF(2^8) inversion plus the affine map.
// Honours AES_INV_KS_ZEROIZE_EN for the post-completion rk value.
module tb_aes_inv_key_sched;

   localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic          clk = 1'b0;
   logic          rstN;
   logic          start;
   logic [127:0]  lastKey;
   logic          rkValid;
   logic          rkReady;
   logic [127:0]  rk;
   logic [3:0]    rkRound;
   logic          busy;
   logic          done;

   int            nCompared = 0;
   int            nMismatched = 0;

   logic [7:0]    sboxModel [256];
   logic [127:0]  modelKeys [11];
   logic [127:0]  gotKey [11];
   logic [3:0]    gotRound [11];
   int            xfers;
   int            cycleCount;
   int            doneEarly;
   int            stallBreaks;

   aes_inv_key_sched dut (
      .i_clk      (clk),
      .i_rst_n    (rstN),
      .i_start    (start),
      .i_last_key (lastKey),
      .o_rk_valid (rkValid),
      .i_rk_ready (rkReady),
      .o_rk       (rk),
      .o_rk_round (rkRound),
      .o_busy     (busy),
      .o_done     (done)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Absolute time limit so a stuck design still produces a verdict line
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] r;
      logic [7:0] s;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         r = inv;
         s = inv;
         for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
         end
         sboxModel[a] = s ^ 8'h63;
      end
   endtask

   // Forward key expansion from a round-0 key into modelKeys[0..10]
   task automatic model_expand(input logic [127:0] k0);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      w[0] = k0[127:96];
      w[1] = k0[95:64];
      w[2] = k0[63:32];
      w[3] = k0[31:0];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sboxModel[t[31:24]], sboxModel[t[23:16]], sboxModel[t[15:8]], sboxModel[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r2 = 0; r2 < 11; r2++)
         modelKeys[r2] = {w[4*r2], w[4*r2+1], w[4*r2+2], w[4*r2+3]};
   endtask

   task automatic pulse_start(input logic [127:0] key);
      @(negedge clk);
      start   = 1'b1;
      lastKey = key;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // Consume keys until 11 transfers or the cycle budget; leaves the bench at
   // the negedge right after the final transfer edge (where done should be 1).
   task automatic collect(input int stallPct, input int startAtRound);
      logic [127:0] heldRk;
      logic [3:0]   heldRound;
      bit           havePrev;
      xfers       = 0;
      doneEarly   = 0;
      stallBreaks = 0;
      havePrev    = 1'b0;
      heldRk      = '0;
      heldRound   = '0;
      for (cycleCount = 0; cycleCount < 300 && xfers < 11; cycleCount++) begin
         if (done) doneEarly++;
         if (havePrev && (rk !== heldRk || rkRound !== heldRound)) stallBreaks++;
         rkReady = ($urandom_range(0, 99) >= stallPct);
         start   = (startAtRound >= 0 && rkValid && rkRound == 4'(startAtRound));
         lastKey = {$urandom, $urandom, $urandom, $urandom};
         if (rkValid && rkReady) begin
            gotKey[xfers]   = rk;
            gotRound[xfers] = rkRound;
            xfers++;
            havePrev = 1'b0;
         end else if (rkValid) begin
            havePrev  = 1'b1;
            heldRk    = rk;
            heldRound = rkRound;
         end
         @(negedge clk);
      end
      start   = 1'b0;
      rkReady = 1'b0;
   endtask

   task automatic test_reset();
      rstN    = 1'b0;
      start   = 1'b0;
      rkReady = 1'b0;
      lastKey = '0;
      #12;
      nCompared++;
      if ({rkValid, busy, done, rkRound, rk} !== 135'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_outputs: got valid=%b busy=%b done=%b round=%0d rk=%h required all zero", rkValid, busy, done, rkRound, rk);
      end
      @(negedge clk);
      rstN    = 1'b1;
      rkReady = 1'b1;
      repeat (3) @(negedge clk);
      nCompared++;
      if (rkValid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL idle_ready_no_effect: got valid=%b busy=%b done=%b required 0 0 0", rkValid, busy, done);
      end
      rkReady = 1'b0;
   endtask

   task automatic test_fips_vector();
      model_expand(FIPS_K0);
      pulse_start(FIPS_K10);
      nCompared++;
      if (rkValid !== 1'b1 || rkRound !== 4'd10 || busy !== 1'b1 || rk !== FIPS_K10) begin
         nMismatched++;
         $display("[TB] FAIL first_key_latency: got valid=%b round=%0d busy=%b rk=%h required 1 10 1 %h", rkValid, rkRound, busy, rk, FIPS_K10);
      end
      collect(0, -1);
      nCompared++;
      if (xfers != 11 || cycleCount != 11) begin
         nMismatched++;
         $display("[TB] FAIL fips_throughput: got %0d transfers in %0d cycles required 11 in 11", xfers, cycleCount);
      end
      for (int j = 0; j < 11; j++) begin
         nCompared++;
         if (gotKey[j] !== modelKeys[10-j] || gotRound[j] !== 4'(10-j)) begin
            nMismatched++;
            $display("[TB] FAIL fips_key[%0d]: got round=%0d rk=%h required round=%0d rk=%h", j, gotRound[j], gotKey[j], 10-j, modelKeys[10-j]);
         end
      end
      nCompared++;
      if (gotKey[1] !== FIPS_K9 || gotKey[9] !== FIPS_K1 || gotKey[10] !== FIPS_K0) begin
         nMismatched++;
         $display("[TB] FAIL fips_known_keys: got r9=%h r1=%h r0=%h required %h %h %h", gotKey[1], gotKey[9], gotKey[10], FIPS_K9, FIPS_K1, FIPS_K0);
      end
      nCompared++;
      if (done !== 1'b1 || busy !== 1'b0 || rkValid !== 1'b0 || doneEarly != 0) begin
         nMismatched++;
         $display("[TB] FAIL fips_done_pulse: got done=%b busy=%b valid=%b early=%0d required 1 0 0 0", done, busy, rkValid, doneEarly);
      end
`ifdef AES_INV_KS_ZEROIZE_EN
      nCompared++;
      if (rk !== 128'h0) begin
         nMismatched++;
         $display("[TB] FAIL zeroize_after_done: got rk=%h required 0", rk);
      end
`else
      nCompared++;
      if (rk !== FIPS_K0) begin
         nMismatched++;
         $display("[TB] FAIL hold_after_done: got rk=%h required %h", rk, FIPS_K0);
      end
`endif
      @(negedge clk);
      nCompared++;
      if (done !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL done_one_cycle: got done=%b required 0", done);
      end
   endtask

   task automatic test_random_stalls();
      logic [127:0] k0;
      for (int it = 0; it < 4; it++) begin
         k0 = {$urandom, $urandom, $urandom, $urandom};
         model_expand(k0);
         pulse_start(modelKeys[10]);
         collect(45, -1);
         nCompared++;
         if (xfers != 11 || stallBreaks != 0 || doneEarly != 0) begin
            nMismatched++;
            $display("[TB] FAIL stall_run%0d: got xfers=%0d unstable=%0d earlyDone=%0d required 11 0 0", it, xfers, stallBreaks, doneEarly);
         end
         for (int j = 0; j < 11; j++) begin
            nCompared++;
            if (gotKey[j] !== modelKeys[10-j] || gotRound[j] !== 4'(10-j)) begin
               nMismatched++;
               $display("[TB] FAIL stall_run%0d_key[%0d]: got round=%0d rk=%h required round=%0d rk=%h", it, j, gotRound[j], gotKey[j], 10-j, modelKeys[10-j]);
            end
         end
         nCompared++;
         if (done !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL stall_run%0d_done: got done=%b required 1", it, done);
         end
         @(negedge clk);
         nCompared++;
         if (done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL stall_run%0d_done_width: got done=%b required 0", it, done);
         end
      end
   endtask

   task automatic test_restart_ignored(input int atRound);
      model_expand(FIPS_K0);
      pulse_start(FIPS_K10);
      collect(20, atRound);
      nCompared++;
      if (xfers != 11) begin
         nMismatched++;
         $display("[TB] FAIL restart_at%0d_count: got %0d transfers required 11", atRound, xfers);
      end
      for (int j = 0; j < 11; j++) begin
         nCompared++;
         if (gotKey[j] !== modelKeys[10-j] || gotRound[j] !== 4'(10-j)) begin
            nMismatched++;
            $display("[TB] FAIL restart_at%0d_key[%0d]: got round=%0d rk=%h required round=%0d rk=%h", atRound, j, gotRound[j], gotKey[j], 10-j, modelKeys[10-j]);
         end
      end
      nCompared++;
      if (done !== 1'b1 || rkValid !== 1'b0 || busy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL restart_at%0d_end: got done=%b valid=%b busy=%b required 1 0 0", atRound, done, rkValid, busy);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int guard;
      int doneSeen;
      model_expand(FIPS_K0);
      pulse_start(FIPS_K10);
      rkReady = 1'b1;
      guard = 0;
      while (!(rkValid && rkRound == 4'd4) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      rkReady = 1'b0;
      nCompared++;
      if (guard >= 50) begin
         nMismatched++;
         $display("[TB] FAIL abort_reach_round4: got round=%0d after %0d cycles required round 4", rkRound, guard);
      end
      #2 rstN = 1'b0;
      #1;
      nCompared++;
      if ({rkValid, busy, done, rkRound, rk} !== 135'h0) begin
         nMismatched++;
         $display("[TB] FAIL abort_async_clear: got valid=%b busy=%b done=%b round=%0d rk=%h required all zero", rkValid, busy, done, rkRound, rk);
      end
      doneSeen = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      rstN = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      nCompared++;
      if (doneSeen != 0 || rkValid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL abort_no_done: got done pulses=%0d valid=%b required 0 0", doneSeen, rkValid);
      end
      pulse_start(FIPS_K10);
      collect(0, -1);
      nCompared++;
      if (xfers != 11) begin
         nMismatched++;
         $display("[TB] FAIL abort_rerun_count: got %0d transfers required 11", xfers);
      end
      for (int j = 0; j < 11; j++) begin
         nCompared++;
         if (gotKey[j] !== modelKeys[10-j]) begin
            nMismatched++;
            $display("[TB] FAIL abort_rerun_key[%0d]: got %h required %h", j, gotKey[j], modelKeys[10-j]);
         end
      end
   endtask

   // Starting again in the very cycle done is high must be accepted.
   task automatic test_back_to_back();
      logic [127:0] k0;
      nCompared++;
      if (done !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL b2b_done_present: got done=%b required 1", done);
      end
      k0 = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k0);
      start   = 1'b1;
      lastKey = modelKeys[10];
      @(negedge clk);
      start   = 1'b0;
      nCompared++;
      if (rkValid !== 1'b1 || rkRound !== 4'd10 || rk !== modelKeys[10]) begin
         nMismatched++;
         $display("[TB] FAIL b2b_start_in_done_cycle: got valid=%b round=%0d rk=%h required 1 10 %h", rkValid, rkRound, rk, modelKeys[10]);
      end
      collect(0, -1);
      nCompared++;
      if (xfers != 11 || gotKey[10] !== k0) begin
         nMismatched++;
         $display("[TB] FAIL b2b_sequence: got xfers=%0d last=%h required 11 %h", xfers, gotKey[10], k0);
      end
      @(negedge clk);
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips_vector();
      test_random_stalls();
      test_restart_ignored(5);
      test_restart_ignored(0);
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
